// File: rtl/pc_fetch_sequencer_if.sv
// Fetch/issue bundle between the PC sequencer, instruction memory and decode/execute.
// master = sequencer side, slave = memory + decode/execute side.
interface pc_fetch_sequencer_if #(
    parameter int CNT_W = 16
);
    logic             run;
    logic             imem_req;
    logic [15:0]      imem_addr;
    logic             imem_ack;
    logic [15:0]      imem_rdata;
    logic             instr_valid;
    logic [15:0]      instr;
    logic [3:0]       opcode;
    logic             exec_done;
    logic             jump;
    logic             beq;
    logic             bne;
    logic             zero;
    logic [15:0]      pc;
    logic [CNT_W-1:0] retired;

    modport master (
        input  run, imem_ack, imem_rdata, exec_done, jump, beq, bne, zero,
        output imem_req, imem_addr, instr_valid, instr, opcode, pc, retired
    );

    modport slave (
        output run, imem_ack, imem_rdata, exec_done, jump, beq, bne, zero,
        input  imem_req, imem_addr, instr_valid, instr, opcode, pc, retired
    );
endinterface

// File: rtl/pc_fetch_sequencer.sv
// Non-pipelined PC sequencer: fetches one 16-bit instruction, holds it for execute,
// then resolves jump/branch to the next PC. Min 2 cycles/instr; req held until ack.
module pc_fetch_sequencer #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pc_fetch_sequencer_if.master bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] REQ   = 2'd1;
    localparam logic [1:0] ISSUE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [15:0]      pc_q, pc_d;
    logic [15:0]      instr_q, instr_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    logic [15:0] pc_inc;
    logic [15:0] jmp_tgt;
    logic [15:0] br_tgt;
    logic        br_taken;
    logic [15:0] next_pc;

    // Jump keeps the top 3 bits of the incremented PC; branch offset is in words.
    assign pc_inc   = pc_q + 16'd2;
    assign jmp_tgt  = {pc_inc[15:13], instr_q[11:0], 1'b0};
    assign br_tgt   = pc_inc + {{9{instr_q[5]}}, instr_q[5:0], 1'b0};
    assign br_taken = (bus.beq && bus.zero) || (bus.bne && !bus.zero);

    always_comb begin
        next_pc = pc_inc;
        if (bus.jump) begin
            next_pc = jmp_tgt;
        end else if (br_taken) begin
            next_pc = br_tgt;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        retired_d = retired_q;
        case (state_q)
            IDLE: begin
                if (bus.run) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (bus.imem_ack) begin
                    instr_d = bus.imem_rdata;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.exec_done) begin
                    pc_d      = next_pc;
                    retired_d = retired_q + CNT_W'(1);
                    state_d   = bus.run ? REQ : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            instr_q   <= 16'h0000;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            retired_q <= retired_d;
        end
    end

    assign bus.imem_req    = (state_q == REQ);
    assign bus.imem_addr   = pc_q;
    assign bus.instr_valid = (state_q == ISSUE);
    assign bus.instr       = instr_q;
    assign bus.opcode      = instr_q[15:12];
    assign bus.pc          = pc_q;
    assign bus.retired     = retired_q;
endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Self-checking bench for pc_fetch_sequencer: directed scenarios plus randomized
// instruction streams compared against an arithmetic next-PC reference.
module tb_pc_fetch_sequencer;
    localparam logic [15:0] RST_PC = 16'h0000;
    localparam int          CW     = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pc_fetch_sequencer_if #(.CNT_W(CW)) bus ();

    pc_fetch_sequencer #(.RESET_PC(RST_PC), .CNT_W(CW)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.master)
    );

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [15:0] m_pc   = RST_PC;
    int          m_ret  = 0;

    // Observations of one instruction
    int          req_cyc, vld_cyc;
    logic [15:0] addr0;
    logic        addr_ok, iss_ok;

    function automatic logic [15:0] ref_next(logic [15:0] pc, logic [15:0] w, logic [3:0] f);
        int inc, off;
        inc = (int'(pc) + 2) % 65536;
        if (f[3]) return 16'((inc / 8192) * 8192 + (int'(w) % 4096) * 2);
        if ((f[2] && f[0]) || (f[1] && !f[0])) begin
            off = int'(w) % 64;
            if (off >= 32) off = off - 64;
            return 16'((inc + 2 * off + 65536) % 65536);
        end
        return 16'(inc);
    endfunction

    // Entered at a negedge with the DUT in REQ; f = {jump, beq, bne, zero}.
    task automatic run_instr(input logic [15:0] w, input int ack_dly, input int ex_dly,
                             input logic [3:0] f, input logic run_after);
        req_cyc = 0; vld_cyc = 0; addr0 = bus.imem_addr; addr_ok = 1'b1; iss_ok = 1'b1;
        for (int i = 0; i <= ack_dly; i++) begin
            if (bus.imem_req === 1'b1) req_cyc++;
            if (bus.imem_addr !== addr0 || bus.instr_valid !== 1'b0) addr_ok = 1'b0;
            bus.imem_ack   = (i == ack_dly);
            bus.imem_rdata = (i == ack_dly) ? w : 16'($urandom);
            bus.exec_done  = 1'($urandom);
            {bus.jump, bus.beq, bus.bne, bus.zero} = 4'($urandom);
            bus.run = 1'($urandom);
            @(negedge clk);
        end
        for (int i = 0; i <= ex_dly; i++) begin
            if (bus.instr_valid === 1'b1) vld_cyc++;
            if (bus.instr !== w || bus.opcode !== w[15:12] || bus.imem_req !== 1'b0) iss_ok = 1'b0;
            bus.imem_ack   = 1'b1;
            bus.imem_rdata = ~w;
            bus.exec_done  = (i == ex_dly);
            {bus.jump, bus.beq, bus.bne, bus.zero} = (i == ex_dly) ? f : 4'($urandom);
            bus.run = (i == ex_dly) ? run_after : 1'($urandom);
            @(negedge clk);
        end
        bus.imem_ack = 1'b0; bus.exec_done = 1'b0;
        {bus.jump, bus.beq, bus.bne, bus.zero} = 4'b0000;
        m_pc  = ref_next(m_pc, w, f);
        m_ret = (m_ret + 1) % (1 << CW);
    endtask

    task automatic test_reset();
        bus.run = 1'b0; bus.imem_ack = 1'b0; bus.imem_rdata = 16'h0; bus.exec_done = 1'b0;
        {bus.jump, bus.beq, bus.bne, bus.zero} = 4'b0000;
        #12;
        n_chk++; if (bus.pc !== RST_PC) begin n_fail++; $display("FAIL rst_pc: got %h want %h", bus.pc, RST_PC); end
        n_chk++; if (bus.instr !== 16'h0) begin n_fail++; $display("FAIL rst_instr: got %h want 0000", bus.instr); end
        n_chk++; if (bus.retired !== '0) begin n_fail++; $display("FAIL rst_retired: got %0d want 0", bus.retired); end
        n_chk++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b want 0", bus.imem_req); end
        n_chk++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", bus.instr_valid); end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        n_chk++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL idle_req: got %b want 0", bus.imem_req); end
    endtask

    task automatic test_basic();
        bus.run = 1'b1;
        @(negedge clk);
        run_instr(16'h2000, 0, 0, 4'b0000, 1'b1);
        n_chk++; if (addr0 !== 16'h0000) begin n_fail++; $display("FAIL basic_addr0: got %h want 0000", addr0); end
        n_chk++; if (req_cyc !== 1 || vld_cyc !== 1) begin n_fail++; $display("FAIL basic_cycles: got req=%0d vld=%0d want 1/1", req_cyc, vld_cyc); end
        n_chk++; if (!iss_ok) begin n_fail++; $display("FAIL basic_issue: got instr=%h want 2000", bus.instr); end
        n_chk++; if (bus.retired !== 8'd1) begin n_fail++; $display("FAIL basic_retired: got %0d want 1", bus.retired); end
        n_chk++; if (bus.opcode !== 4'h2) begin n_fail++; $display("FAIL basic_opcode: got %h want 2", bus.opcode); end
        run_instr(16'h2000, 0, 0, 4'b0000, 1'b1);
        n_chk++; if (addr0 !== 16'h0002) begin n_fail++; $display("FAIL basic_addr1: got %h want 0002", addr0); end
        n_chk++; if (bus.pc !== 16'h0004) begin n_fail++; $display("FAIL basic_pc: got %h want 0004", bus.pc); end
    endtask

    task automatic test_ack_delay();
        run_instr(16'h5A5A, 3, 2, 4'b0000, 1'b1);
        n_chk++; if (req_cyc !== 4) begin n_fail++; $display("FAIL ackdly_req: got %0d want 4", req_cyc); end
        n_chk++; if (!addr_ok || addr0 !== 16'h0004) begin n_fail++; $display("FAIL ackdly_addr: got %h stable=%b want 0004", addr0, addr_ok); end
        n_chk++; if (!iss_ok || vld_cyc !== 3) begin n_fail++; $display("FAIL ackdly_issue: got ok=%b vld=%0d want 1/3", iss_ok, vld_cyc); end
        n_chk++; if (bus.pc !== 16'h0006) begin n_fail++; $display("FAIL ackdly_pc: got %h want 0006", bus.pc); end
    endtask

    task automatic test_branch();
        logic [15:0] exp_pc [4] = '{16'h000E, 16'h0012, 16'h000E, 16'h000E};
        logic [3:0]  flg    [4] = '{4'b0101, 4'b0100, 4'b0010, 4'b0110};
        for (int k = 0; k < 4; k++) begin
            run_instr(16'hA008, 0, 0, 4'b1000, 1'b1);
            n_chk++; if (bus.pc !== 16'h0010) begin n_fail++; $display("FAIL br_setup%0d: got %h want 0010", k, bus.pc); end
            run_instr(16'hB03E, 1, 1, flg[k], 1'b1);
            n_chk++; if (bus.pc !== exp_pc[k]) begin n_fail++; $display("FAIL br_case%0d: got %h want %h", k, bus.pc, exp_pc[k]); end
        end
    endtask

    task automatic test_jump();
        logic [15:0] w   [4] = '{16'hAFFF, 16'hAFFF, 16'hA010, 16'hD123};
        logic [3:0]  flg [4] = '{4'b1000, 4'b1000, 4'b1000, 4'b1101};
        logic [15:0] exp [4] = '{16'h1FFE, 16'h3FFE, 16'h4020, 16'h4246};
        for (int k = 0; k < 4; k++) begin
            run_instr(w[k], 0, 0, flg[k], 1'b1);
            n_chk++; if (bus.pc !== exp[k]) begin n_fail++; $display("FAIL jump%0d: got %h want %h", k, bus.pc, exp[k]); end
        end
    endtask

    task automatic test_wrap();
        @(negedge clk); rst_n = 1'b0;
        m_pc = RST_PC; m_ret = 0;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        run_instr(16'hB03E, 0, 0, 4'b0101, 1'b1);
        n_chk++; if (bus.pc !== 16'hFFFE) begin n_fail++; $display("FAIL wrap_neg: got %h want fffe", bus.pc); end
        run_instr(16'h1234, 0, 0, 4'b0000, 1'b1);
        n_chk++; if (bus.pc !== 16'h0000) begin n_fail++; $display("FAIL wrap_pc: got %h want 0000", bus.pc); end
        while (m_ret != (1 << CW) - 1) run_instr(16'h0000, 0, 0, 4'b0000, 1'b1);
        n_chk++; if (bus.retired !== 8'hFF) begin n_fail++; $display("FAIL wrap_ret_max: got %0d want 255", bus.retired); end
        run_instr(16'h0000, 0, 0, 4'b0000, 1'b1);
        n_chk++; if (bus.retired !== 8'h00) begin n_fail++; $display("FAIL wrap_ret: got %0d want 0", bus.retired); end
    endtask

    task automatic test_random();
        logic [15:0] w;
        int ad, ed;
        logic ra;
        for (int n = 0; n < 300; n++) begin
            w  = 16'($urandom);
            ad = $urandom_range(0, 3);
            ed = $urandom_range(0, 3);
            ra = ($urandom_range(0, 7) != 0);
            run_instr(w, ad, ed, 4'($urandom), ra);
            n_chk++; if (req_cyc !== ad + 1 || !addr_ok || addr0 !== (bus.pc === m_pc ? addr0 : 16'hxxxx))
                begin n_fail++; $display("FAIL rnd_req%0d: got req=%0d stable=%b want %0d", n, req_cyc, addr_ok, ad + 1); end
            n_chk++; if (vld_cyc !== ed + 1 || !iss_ok) begin n_fail++; $display("FAIL rnd_issue%0d: got vld=%0d ok=%b want %0d", n, vld_cyc, iss_ok, ed + 1); end
            n_chk++; if (bus.pc !== m_pc) begin n_fail++; $display("FAIL rnd_pc%0d: got %h want %h", n, bus.pc, m_pc); end
            n_chk++; if (bus.retired !== CW'(m_ret)) begin n_fail++; $display("FAIL rnd_ret%0d: got %0d want %0d", n, bus.retired, m_ret); end
            if (!ra) begin
                for (int k = 0; k < $urandom_range(1, 3); k++) begin
                    bus.imem_ack = 1'($urandom); bus.exec_done = 1'($urandom);
                    @(negedge clk);
                    n_chk++; if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0 || bus.pc !== m_pc)
                        begin n_fail++; $display("FAIL rnd_idle%0d: got req=%b vld=%b pc=%h want 0/0/%h", n, bus.imem_req, bus.instr_valid, bus.pc, m_pc); end
                end
                bus.imem_ack = 1'b0; bus.exec_done = 1'b0; bus.run = 1'b1;
                @(negedge clk);
            end
            n_chk++; if (bus.imem_addr !== m_pc || bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL rnd_next_addr%0d: got %h req=%b want %h", n, bus.imem_addr, bus.imem_req, m_pc); end
        end
    endtask

    task automatic test_run_low_reset();
        logic [15:0] pc_exp;
        pc_exp = ref_next(m_pc, 16'h3000, 4'b0000);
        run_instr(16'h3000, 0, 1, 4'b0000, 1'b0);
        n_chk++; if (bus.pc !== pc_exp) begin n_fail++; $display("FAIL stop_pc: got %h want %h", bus.pc, pc_exp); end
        @(negedge clk);
        n_chk++; if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL stop_idle: got req=%b vld=%b want 0/0", bus.imem_req, bus.instr_valid); end
        bus.run = 1'b1;
        @(negedge clk);
        n_chk++; if (bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL restart_req: got %b want 1", bus.imem_req); end
        #2 rst_n = 1'b0;
        #1;
        n_chk++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL async_req: got %b want 0", bus.imem_req); end
        bus.run = 1'b0; bus.imem_ack = 1'b1; bus.imem_rdata = 16'hFFFF;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus.imem_ack = 1'b0;
        n_chk++; if (bus.pc !== RST_PC || bus.retired !== '0) begin n_fail++; $display("FAIL post_rst: got pc=%h ret=%0d want %h/0", bus.pc, bus.retired, RST_PC); end
        n_chk++; if (bus.instr !== 16'h0 || bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL post_rst_ack: got instr=%h req=%b want 0000/0", bus.instr, bus.imem_req); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ack_delay();
        test_branch();
        test_jump();
        test_wrap();
        test_random();
        test_run_low_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/pc_fetch_sequencer.md
Name: pc_fetch_sequencer

Overview:
- Produces the instruction stream that the opcode decoder consumes.
- Owns the program counter and fetches 16-bit instructions from instruction memory over a req/ack handshake.
- Presents the fetched instruction and its opcode field to decode/execute.
- Computes the next PC from the jump/beq/bne/zero results returned once the instruction completes. Non-pipelined, single instruction in flight.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- run  input  1  fetch enable; low parks the sequencer in IDLE after the current instruction.
- imem_req  output  1  fetch request; held high until acked.
- imem_addr  output  16  byte address of the fetch; equals pc while imem_req is high.
- imem_ack  input  1  instruction memory has valid data on imem_rdata this cycle.
- imem_rdata  input  16  instruction word.
- instr_valid  output  1  instr/opcode are valid and held for execute.
- instr  output  16  captured instruction register.
- opcode  output  4  instr[15:12], driven to the decoder.
- exec_done  input  1  execute has finished the presented instruction; the flags below are sampled this cycle.
- jump, beq, bne  input  1 each  decoder outputs for the presented instruction.
- zero  input  1  ALU zero flag for the presented instruction.
- pc  output  16  current PC.
- retired  output  CNT_W  count of completed instructions.

Behaviour:
- Reset, asynchronous, while rst_n=0:
  - pc=RESET_PC, instr=16'h0000, retired=0.
  - imem_req=0, instr_valid=0, state=IDLE.
- IDLE: all outputs held; imem_req=0, instr_valid=0. If run=1 at a rising edge, go to REQ.
- REQ:
  - imem_req=1 and imem_addr=pc, combinationally from state.
  - On a rising edge with imem_ack=1, capture instr<=imem_rdata and go to ISSUE. Ack may arrive in the first REQ cycle.
  - imem_ack=0 keeps the sequencer in REQ, no timeout.
  - run is ignored in REQ; a started fetch always completes.
- ISSUE:
  - instr_valid=1; instr and opcode stay stable until exec_done.
  - On a rising edge with exec_done=1: pc<=next_pc, retired<=retired+1 (wraps modulo 2^CNT_W). Next state is REQ if run=1, else IDLE.
- next_pc, using pc_inc = pc+2 (16-bit, wraps 16'hFFFE to 16'h0000):
  - jump=1: {pc_inc[15:13], instr[11:0], 1'b0}. Jump has highest priority.
  - else beq=1 and zero=1, or bne=1 and zero=0: pc_inc + ({{9{instr[5]}}, instr[5:0], 1'b0}). Sign-extended word offset, 16-bit wrap.
  - beq and bne both 1 (illegal): beq=1 with zero=1 takes the branch; otherwise bne=1 with zero=0 takes the branch.
  - else: pc_inc.
- Ignored inputs:
  - imem_ack outside REQ has no effect.
  - exec_done outside ISSUE has no effect.
- Latency: minimum 2 cycles per instruction (1 REQ + 1 ISSUE).
- Reset asserted mid-REQ or mid-ISSUE: imem_req and instr_valid drop immediately (asynchronous). The pending fetch is abandoned and any later ack is ignored.
- pc[0] is always 0 by construction; RESET_PC must be even.

Test Plan:
- Reset then run=1, immediate ack, imem_rdata=16'h2000, exec_done in the first ISSUE cycle with no flags. Expect fetch addrs 0x0000 then 0x0002; instr_valid high 1 cycle in each 2; retired=1 after the first exec_done.
- Ack delayed 3 cycles. Expect imem_req high for 4 cycles with imem_addr=0x0000 stable; instr captured only on the ack cycle; extra acks while in ISSUE ignored.
- instr=16'hB03E (BEQ, offset -2) at pc=0x0010 with beq=1, zero=1. Expect next pc=0x000E. Repeat with zero=0: expect 0x0012. Same word with bne=1, zero=0: expect 0x000E.
- pc=0x4020, instr=16'hD123, jump=1 with beq=1, zero=1 also set. Expect pc=0x4246; jump wins.
- pc=0xFFFE, no branch. Expect pc=0x0000. With retired=16'hFFFF, one more retire gives 0.
- run=0 asserted during ISSUE. Expect pc to advance on exec_done, then IDLE with imem_req=0. Then assert rst_n=0 mid-REQ: imem_req=0 immediately; after release pc=RESET_PC and retired=0.
